// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle CPU control unit.
// Holds the opcode map, the ALU function codes, the FSM state encodings,
// the PC-source and write-back-source mux codes, and a helper that
// classifies an opcode as an ALU (R-type or immediate) instruction.
package ctrl_pkg;

    // Opcode map, taken from IR bits [31:26]
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU function codes; ADD is 000 so an idle control word selects ADD
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // PC source mux codes
    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JR     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Register-file write data source codes
    localparam logic [1:0] WRSRC_ALU = 2'b00;
    localparam logic [1:0] WRSRC_MEM = 2'b01;
    localparam logic [1:0] WRSRC_PC4 = 2'b10;

    // FSM states; encodings are visible on the debug state port
    typedef enum logic [3:0] {
        sIF   = 4'd0,
        sID   = 4'd1,
        sEXE  = 4'd2,
        sLS   = 4'd3,
        sMEM  = 4'd4,
        sBR   = 4'd5,
        sWB   = 4'd6,
        sLWB  = 4'd7,
        sHALT = 4'd8
    } state_t;

    // True for every opcode that goes through execute and write-back
    function automatic logic isAluOp(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
            OP_AND, OP_OR, OP_SLL, OP_SLT: isAluOp = 1'b1;
            default:                       isAluOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode -> ALU function and operand-B select.
// Ports:
//   opcode  in   6  instruction opcode
//   aluOp   out  3  ALU function code
//   aluSrcB out  1  0 = rt, 1 = extended immediate
// Non-ALU opcodes decode to ADD with rt, a harmless idle setting.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] aluOp,
    output logic       aluSrcB
);

    // Only ADDI and ORI take the immediate as operand B; SLL takes its
    // shift amount from the instruction's shamt path, not operand B.
    always_comb begin
        aluOp   = ALU_ADD;
        aluSrcB = 1'b0;
        case (opcode)
            OP_ADD:  aluOp = ALU_ADD;
            OP_ADDI: begin
                aluOp   = ALU_ADD;
                aluSrcB = 1'b1;
            end
            OP_SUB:  aluOp = ALU_SUB;
            OP_ORI:  begin
                aluOp   = ALU_OR;
                aluSrcB = 1'b1;
            end
            OP_AND:  aluOp = ALU_AND;
            OP_OR:   aluOp = ALU_OR;
            OP_SLL:  aluOp = ALU_SLL;
            OP_SLT:  aluOp = ALU_SLT;
            default: begin
                aluOp   = ALU_ADD;
                aluSrcB = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle CPU datapath.
// Steps each instruction through fetch, decode, execute/branch/address,
// memory and write-back, and drives the datapath strobes and mux selects.
// Ports:
//   clk        in   1        system clock, rising edge
//   Reset      in   1        asynchronous active-low reset
//   opcode     in   OP_W     IR[31:26], stable for the whole instruction
//   zero       in   1        ALU zero flag, used in sBR
//   ins_ready  in   1        instruction memory data valid (sampled in sIF)
//   mem_ready  in   1        data memory access complete (sampled in sMEM)
//   IRWre      out  1        IR load enable
//   PCWre      out  1        PC load enable, once per instruction
//   PCSrc      out  2        PC source select
//   RegWre     out  1        register file write enable
//   WrRegDSrc  out  2        register write data select
//   ALUSrcB    out  1        ALU operand B select
//   ALUOp      out  3        ALU function code
//   MemRead    out  1        data memory read strobe
//   MemWrite   out  1        data memory write strobe
//   state      out  STATE_W  current state, for debug
//   halted     out  1        high in sHALT
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               ins_ready,
    input  logic               mem_ready,
    output logic               IRWre,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               RegWre,
    output logic [1:0]         WrRegDSrc,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [STATE_W-1:0] state,
    output logic               halted
);

    state_t     curState;
    logic [5:0] opc;
    logic [2:0] decAluOp;
    logic       decSrcB;

    assign opc   = 6'(opcode);
    assign state = STATE_W'(curState);

    alu_op_decode uDecode (
        .opcode  (opc),
        .aluOp   (decAluOp),
        .aluSrcB (decSrcB)
    );

    // State register and transitions. sHALT has no way out except Reset.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            curState <= sIF;
        end else begin
            case (curState)
                sIF:   if (ins_ready) curState <= sID;
                sID: begin
                    if (isAluOp(opc)) begin
                        curState <= sEXE;
                    end else begin
                        case (opc)
                            OP_BEQ, OP_BNE: curState <= sBR;
                            OP_LW, OP_SW:   curState <= sLS;
                            OP_HALT:        curState <= sHALT;
                            // J, JAL, JR and undefined opcodes complete in decode
                            default:        curState <= sIF;
                        endcase
                    end
                end
                sEXE:  curState <= sWB;
                sWB:   curState <= sIF;
                sBR:   curState <= sIF;
                sLS:   curState <= sMEM;
                sMEM:  if (mem_ready) curState <= (opc == OP_LW) ? sLWB : sIF;
                sLWB:  curState <= sIF;
                sHALT: curState <= sHALT;
                default: curState <= sIF;
            endcase
        end
    end

    // Control word decode. Everything is gated by Reset so that pulling
    // Reset low silences every strobe at once, even if ins_ready is high
    // while the FSM sits in sIF.
    always_comb begin
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = PCSRC_PC4;
        RegWre    = 1'b0;
        WrRegDSrc = WRSRC_ALU;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        halted    = 1'b0;
        if (Reset) begin
            case (curState)
                sIF: IRWre = ins_ready;
                sID: begin
                    if (!isAluOp(opc)) begin
                        case (opc)
                            OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_HALT: ;
                            OP_J: begin
                                PCWre = 1'b1;
                                PCSrc = PCSRC_JUMP;
                            end
                            OP_JAL: begin
                                PCWre     = 1'b1;
                                PCSrc     = PCSRC_JUMP;
                                RegWre    = 1'b1;
                                WrRegDSrc = WRSRC_PC4;
                            end
                            OP_JR: begin
                                PCWre = 1'b1;
                                PCSrc = PCSRC_JR;
                            end
                            // Undefined opcode behaves as a NOP
                            default: PCWre = 1'b1;
                        endcase
                    end
                end
                sEXE: begin
                    ALUOp   = decAluOp;
                    ALUSrcB = decSrcB;
                end
                sWB: begin
                    ALUOp   = decAluOp;
                    ALUSrcB = decSrcB;
                    RegWre  = 1'b1;
                    PCWre   = 1'b1;
                end
                sBR: begin
                    ALUOp = ALU_SUB;
                    PCWre = 1'b1;
                    if (((opc == OP_BEQ) && zero) || ((opc == OP_BNE) && !zero))
                        PCSrc = PCSRC_BRANCH;
                end
                sLS: ALUSrcB = 1'b1;
                sMEM: begin
                    ALUSrcB  = 1'b1;
                    MemRead  = (opc == OP_LW);
                    MemWrite = (opc == OP_SW);
                    // A store finishes here; a load still needs its write-back
                    PCWre    = mem_ready && (opc == OP_SW);
                end
                sLWB: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = WRSRC_MEM;
                    PCWre     = 1'b1;
                end
                sHALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
